dmem_mmio_console: RTL
======================

Name: dmem_mmio_console

Overview:
Memory-mapped responder on the CPU core's data-memory bus. It sits beside the data RAM and decodes a 16-byte MMIO window at the top of the 10-bit DMEM address space. Stores to that window push console bytes into a FIFO and set a halt/exit-code flag. The FIFO drains through a valid/ready byte stream. This lets test programs (sorting, etc.) report results and terminate cleanly, instead of the bench waiting on an all-zero instruction.

Parameters:
FIFO_DEPTH, 8, console FIFO entries; power of two, minimum 2.
BASE_ADDR, 10'h3F0, byte address of the MMIO window; 16-byte aligned.

Ports:
CLK  input  1  system clock; all state updates on its rising edge.
RST  input  1  synchronous, active-high reset.
MemWrite  input  1  CPU store strobe.
MemRead  input  1  CPU load strobe.
address  input  10  CPU byte address (DMEM).
write_data  input  32  CPU store data.
read_data  output  32  load data; combinational.
hit  output  1  combinational; 1 when address[9:4]==BASE_ADDR[9:4]; the top level uses it to gate RAM MemWrite and select read_data.
tx_valid  output  1  FIFO head byte available.
tx_data  output  8  FIFO head byte.
tx_ready  input  1  consumer accepts the byte when tx_valid and tx_ready are both 1 at the rising edge.
halted  output  1  sticky program-halt flag.
exit_code  output  32  value written to HALT.

Behaviour:
- Register map: offset = address[3:2]; address[1:0] is ignored.
  - 0x0 TXDATA (W): push write_data[7:0] into the FIFO.
  - 0x4 STATUS (R/W1C), bit fields:
    - bit0 full
    - bit1 empty
    - bit2 halted
    - bit3 overflow, sticky
    - bits[11:8] occupancy count, saturating at 15
    - all other bits 0
  - 0x8 HALT (W): latch exit code; reads return exit_code.
  - 0xC CYCLES (R): see Optional Feature.
- Writes take effect at the rising edge when MemWrite=1 and hit=1. Writes to read-only offsets are ignored.
- Reads:
  - read_data is combinational from address whenever hit=1. It is 0 when hit=0, independent of MemRead.
  - Reads have no side effects.
  - MemRead and MemWrite both 1: the write still occurs; read_data shows the pre-edge value.
- FIFO:
  - tx_valid = !empty; tx_data = head entry. tx_data is 0 when empty.
  - A push into an empty FIFO makes tx_valid 1 on the cycle after the push edge. There is no bypass.
  - Pop on tx_valid & tx_ready.
  - Push when full with no pop in the same cycle: the byte is dropped and overflow is set.
  - Push when full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - Simultaneous push and pop at any occupancy: the count is unchanged; pointers wrap modulo FIFO_DEPTH.
  - A tx_ready pulse with tx_valid=0 has no effect.
- STATUS write: overflow is cleared when write_data[3]=1; all other bits are ignored.
- HALT:
  - The first HALT write sets halted=1 and exit_code=write_data.
  - Further HALT writes are ignored until reset.
  - TXDATA pushes and FIFO draining continue while halted.
- Reset (RST=1 at an edge), including mid-transfer:
  - pointers and count to 0, overflow=0, halted=0, exit_code=0, cycle counter=0.
  - Consequently tx_valid=0 and tx_data=0 after that edge.
  - Unread FIFO bytes are discarded. Reset overrides any simultaneous write or pop.

Optional Feature:
DMEM_MMIO_CYCLES_EN.
- Defined: a 32-bit free-running counter increments every cycle after reset and wraps 0xFFFFFFFF->0. It stops incrementing once halted=1, freezing the program's runtime. Offset 0xC returns its value.
- Undefined: no counter is implemented and offset 0xC reads 0.

Test Plan:
1. Reset, then store 0x41, 0x42, 0x43 to 0x3F0 with tx_ready=0. Expected: STATUS reads count=3, empty=0. Then raise tx_ready: tx_data shows 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0 and empty=1.
2. With FIFO_DEPTH=8 and tx_ready=0, perform 9 pushes. Expected: full=1, count=8, overflow=1, and the 9th byte is absent from the drain. Store 0x8 to 0x3F4: overflow=0.
3. With the FIFO full, push 0x55 while tx_ready=1. Expected: count stays 8 and 0x55 is the last byte drained.
4. Store 0x0000002A to 0x3F8, then 0x7. Expected: halted=1, exit_code=0x2A, STATUS bit2=1, and a read of 0x3F8 returns 0x2A.
5. Load from 0x100. Expected: hit=0, read_data=0. Store to 0x100. Expected: no FIFO or halt change.
6. Assert RST with 3 bytes queued and halted=1. Expected: tx_valid=0, halted=0, exit_code=0, and STATUS reads 0x2 next cycle. With DMEM_MMIO_CYCLES_EN defined: CYCLES increments by 1 per cycle and freezes after halt.

Source files
------------

// File: rtl/dmem_mmio_console.sv
// MMIO responder for the DMEM bus: console byte FIFO, status, halt/exit code.
// Optional free-running runtime counter at offset 0xC when DMEM_MMIO_CYCLES_EN is defined.
module dmem_mmio_console #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [9:0]  BASE_ADDR  = 10'h3F0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [9:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic [31:0] exit_code
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SAT_W = (CNT_W > 4) ? CNT_W : 4;

  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_HALT   = 2'd2,
    OFF_CYCLES = 2'd3
  } reg_off_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             halted_q, halted_d;
  logic [31:0]      exit_code_q, exit_code_d;

  reg_off_e         offset;
  logic             wr_en;
  logic             push;
  logic             pop;
  logic             push_accept;
  logic             full;
  logic             empty;
  logic [SAT_W-1:0] count_wide;
  logic [3:0]       count_sat;
  logic [31:0]      status_word;
  logic [31:0]      cycles_val;
  logic             unused_inputs;

  assign hit    = (address[9:4] == BASE_ADDR[9:4]);
  assign offset = reg_off_e'(address[3:2]);
  assign wr_en  = MemWrite & hit;

  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty  = (count_q == '0);

  assign push        = wr_en && (offset == OFF_TXDATA);
  assign pop         = tx_valid & tx_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_accept = push && (!full || pop);

  assign count_wide  = SAT_W'(count_q);
  assign count_sat   = (count_wide > SAT_W'(15)) ? 4'hF : count_wide[3:0];
  assign status_word = {20'h0, count_sat, 4'h0, overflow_q, halted_q, empty, full};

  assign tx_valid  = !empty;
  assign tx_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign halted    = halted_q;
  assign exit_code = exit_code_q;

  assign unused_inputs = ^{MemRead, address[1:0]};

`ifdef DMEM_MMIO_CYCLES_EN
  logic [31:0] cycles_q, cycles_d;

  // Runtime stops counting once the program halts.
  always_comb begin
    cycles_d = cycles_q;
    if (!halted_q) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycles_q <= 32'h0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_val = cycles_q;
`else
  assign cycles_val = 32'h0;
`endif

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    halted_d    = halted_q;
    exit_code_d = exit_code_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push_accept) begin
      mem_d[wr_ptr_q] = write_data[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else if (push) begin
      overflow_d = 1'b1;
    end

    case ({push_accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_en && (offset == OFF_STATUS) && write_data[3]) begin
      overflow_d = 1'b0;
    end

    // Only the first HALT store counts; later ones keep the original exit code.
    if (wr_en && (offset == OFF_HALT) && !halted_q) begin
      halted_d    = 1'b1;
      exit_code_d = write_data;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      halted_q    <= 1'b0;
      exit_code_q <= 32'h0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      halted_q    <= halted_d;
      exit_code_q <= exit_code_d;
    end
  end

  always_comb begin
    read_data = 32'h0;
    if (hit) begin
      case (offset)
        OFF_STATUS: read_data = status_word;
        OFF_HALT:   read_data = exit_code_q;
        OFF_CYCLES: read_data = cycles_val;
        default:    read_data = 32'h0;
      endcase
    end
  end

endmodule
